seq_restoring_divider: RTL and testbench

Sequential unsigned restoring divider: 8-bit dividend by 4-bit divisor, giving an 8-bit quotient and a 4-bit remainder. It computes one quotient bit per clock through a start/busy/done handshake. It is the inverse operation to the combinational 4x4 array multiplier and sits beside it in the tile top level. The top level drives operands from the dedicated inputs and muxes results onto the dedicated outputs.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 33 +++
 rtl/seq_restoring_divider.sv | 147 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and FSM state type for the sequential restoring divider
//
// Contents:
//   DEF_DIVIDEND_W  default dividend / quotient width
//   DEF_DIVISOR_W   default divisor / remainder width
//   DEF_CNT_W       bit-counter width for the default dividend width
//   state_e         IDLE / RUN / DONE
package div_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;
    localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Ports:
//   rem_i      partial remainder entering the step
//   bit_i      next dividend bit, MSB first
//   divisor_i  divisor
//   rem_o      partial remainder leaving the step
//   qbit_o     quotient bit produced by the step
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 qbit_o
);

    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] diff;
    logic               ge;

    always_comb begin
        trial  = {rem_i, bit_i};
        ge     = (trial >= {1'b0, divisor_i});
        diff   = trial - {1'b0, divisor_i};
        // When the subtraction succeeds the difference is below the divisor,
        // so it always fits back into the remainder width.
        rem_o  = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
        qbit_o = ge;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, honoured only in IDLE or DONE
//   dividend      dividend, captured on an accepted start
//   divisor       divisor, captured on an accepted start
//   busy          high while the FSM is in RUN
//   done          one-cycle pulse, quotient/remainder valid
//   quotient      registered result, held until the next accepted start completes
//   remainder     registered result, held until the next accepted start completes
//   div_by_zero   registered zero-divisor flag
//
// Build option DIV_ZERO_DETECT_EN: a zero divisor bypasses RUN and reports
// div_by_zero. Without it the zero divisor runs the full loop (which naturally
// yields all-ones quotient and dividend low bits as remainder) and
// div_by_zero is tied low.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom, so after the last step this register holds the quotient.
    logic [DIVIDEND_W-1:0]   work_q, work_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
`ifdef DIV_ZERO_DETECT_EN
    logic                    dbz_q, dbz_d;
`endif

    logic [DIVISOR_W-1:0]    step_rem;
    logic                    step_qbit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d       = dbz_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    work_d  = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DIVIDEND_W - 1);
                    state_d = ST_RUN;
`ifdef DIV_ZERO_DETECT_EN
                    dbz_d   = 1'b0;
                    if (divisor == '0) begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend[DIVISOR_W-1:0];
                        dbz_d       = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                work_d = {work_q[DIVIDEND_W-2:0], step_qbit};
                rem_d  = step_rem;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = ST_DONE;
                    quotient_d  = {work_q[DIVIDEND_W-2:0], step_qbit};
                    remainder_d = step_rem;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - scoreboard bench for seq_restoring_divider
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int q;
        int r;
        int z;
        int acc;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   last_q = 0;
    int   last_r = 0;

    seq_restoring_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected result for a start accepted on the edge numbered acc.
    function automatic exp_t mk(input int a, input int b, input int acc);
        exp_t e;
        e.q   = (b == 0) ? 255 : a / b;
        e.r   = (b == 0) ? (a % 16) : (a % b);
        e.acc = acc;
`ifdef DIV_ZERO_DETECT_EN
        // Zero divisor goes straight to DONE on the accepting edge.
        e.z   = (b == 0) ? 1 : 0;
        e.lat = (b == 0) ? 0 : 8;
`else
        e.z   = 0;
        e.lat = 8;
`endif
        return e;
    endfunction

    // Called just after a negedge; returns just after the following negedge.
    task automatic start_op(input int a, input int b);
        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(a, b, cyc));
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    // Monitor: pops an expectation on every done and checks result hold during RUN.
    always @(negedge clk) begin
        if (rst) begin
            last_q = 0;
            last_r = 0;
        end else begin
            if (busy) begin
                chk("hold_quotient", quotient, last_q);
                chk("hold_remainder", remainder, last_r);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.z);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("busy_in_done", busy, 0);
                    last_q = e.q;
                    last_r = e.r;
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);

        // Release reset with start already high: sampled at the first edge.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(200, 7, cyc));
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        wait_done();

        // Back-to-back: second start issued in the DONE cycle.
        start_op(255, 15);
        wait_done();
        start_op(5, 9);
        wait_done();

        // Zero divisor.
        start_op(8'hA3, 0);
        wait_done();

        // A start during RUN must be ignored.
        @(negedge clk);
        start_op(100, 3);
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);

        // Reset in the 4th busy cycle aborts the operation.
        start_op(200, 7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        start_op(9, 2);
        wait_done();

        // Sweep every nonzero-divisor pair with random gaps (0 = start in DONE).
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                start_op(a, b);
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
